// File: rtl/rv32i_pkg.sv
// Shared RV32I encoding constants, expander FSM states and instruction-word builders.
// Imported by the load-immediate splitter and expander.
package rv32i_pkg;

   localparam logic [6:0]  OPC_LUI    = 7'b0110111;
   localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
   localparam logic [2:0]  F3_ADDI    = 3'b000;
   localparam logic [31:0] NOP_WORD   = 32'h00000013;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FIRST  = 2'd1,
      SECOND = 2'd2
   } li_state_e;

   function automatic logic [31:0] enc_lui(input logic [19:0] imm20, input logic [4:0] rd);
      return {imm20, rd, OPC_LUI};
   endfunction

   function automatic logic [31:0] enc_addi(input logic [11:0] imm12, input logic [4:0] rs1,
                                            input logic [4:0] rd);
      return {imm12, rs1, F3_ADDI, rd, OPC_OP_IMM};
   endfunction

endpackage

// File: rtl/li_splitter.sv
// Combinational classifier: turns a 32-bit constant and rd into the minimal
// ADDI / LUI / LUI+ADDI instruction sequence.
module li_splitter
   import rv32i_pkg::*;
(
   input  logic [31:0] value,
   input  logic [4:0]  rd,
   output logic [1:0]  word_count,
   output logic [31:0] first_word,
   output logic [31:0] second_word
);

   logic        fits_s12;
   logic        lo_zero;
   logic [19:0] hi_adj;

   assign fits_s12 = (value[31:11] == {21{value[31]}});
   assign lo_zero  = (value[11:0] == 12'd0);
   // ADDI sign-extends lo12, so pre-compensate the upper part when bit 11 is set.
   assign hi_adj   = value[31:12] + {19'd0, value[11]};

   always_comb begin
      word_count  = 2'd1;
      first_word  = NOP_WORD;
      second_word = enc_addi(value[11:0], rd, rd);
      if (rd == 5'd0) begin
         word_count = 2'd1;
         first_word = NOP_WORD;
      end else if (fits_s12) begin
         word_count = 2'd1;
         first_word = enc_addi(value[11:0], 5'd0, rd);
      end else if (lo_zero) begin
         word_count = 2'd1;
         first_word = enc_lui(value[31:12], rd);
      end else begin
         word_count = 2'd2;
         first_word = enc_lui(hi_adj, rd);
      end
   end

endmodule

// File: rtl/li_expander.sv
// Load-immediate expander: accepts {rd, value} requests and streams the RV32I words
// that materialise the constant over a valid/ready output with registered outputs.
module li_expander
   import rv32i_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_rd,
   input  logic [31:0] in_value,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic        out_last
);

   li_state_e   state_q, state_d;
   logic [31:0] instr_q, instr_d;
   logic        last_q, last_d;
   logic [31:0] second_q, second_d;

   logic [1:0]  split_count;
   logic [31:0] split_first;
   logic [31:0] split_second;
   logic        in_hs;
   logic        out_hs;

   li_splitter u_splitter (
      .value       (in_value),
      .rd          (in_rd),
      .word_count  (split_count),
      .first_word  (split_first),
      .second_word (split_second)
   );

   assign out_valid = (state_q != IDLE);
   assign out_instr = instr_q;
   assign out_last  = last_q;
   // A new request may enter in the same cycle the final word of the current one leaves.
   assign in_ready  = !reset && ((state_q == IDLE) || (out_valid && last_q && out_ready));
   assign in_hs     = in_valid && in_ready;
   assign out_hs    = out_valid && out_ready;

   always_comb begin
      state_d  = state_q;
      instr_d  = instr_q;
      last_d   = last_q;
      second_d = second_q;
      if (in_hs) begin
         state_d  = FIRST;
         instr_d  = split_first;
         last_d   = (split_count == 2'd1);
         second_d = split_second;
      end else if (out_hs) begin
         case (state_q)
            FIRST: begin
               if (!last_q) begin
                  state_d = SECOND;
                  instr_d = second_q;
                  last_d  = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
            SECOND:  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         instr_q  <= 32'd0;
         last_q   <= 1'b0;
         second_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         instr_q  <= instr_d;
         last_q   <= last_d;
         second_q <= second_d;
      end
   end

endmodule

// File: tb/tb_li_expander.sv
// Self-checking bench for li_expander: directed cases plus randomized traffic
// scored against an arithmetic reference model of the load-immediate rules.
module tb_li_expander;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rd;
   logic [31:0] in_value;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_last;

   int checks = 0;
   int errors = 0;
   logic [32:0] exp_q[$];

   li_expander dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_rd     (in_rd),
      .in_value  (in_value),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_last  (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
         errors++;
         $error("%s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_lui(input int unsigned hi, input int unsigned rd);
      return 32'(hi * 4096 + rd * 128 + 55);
   endfunction

   function automatic logic [31:0] m_addi(input int unsigned imm, input int unsigned rs1,
                                          input int unsigned rd);
      return 32'(imm * 1048576 + rs1 * 32768 + rd * 128 + 19);
   endfunction

   // Reference: pushes the expected {last, word} sequence for one accepted request.
   function automatic void model_push(input logic [31:0] v, input logic [4:0] rd);
      int          sv;
      int          lo_s;
      int unsigned lo_u;
      logic [31:0] up;
      sv   = $signed(v);
      lo_u = v % 4096;
      lo_s = (lo_u >= 2048) ? int'(lo_u) - 4096 : int'(lo_u);
      if (rd == 5'd0) begin
         exp_q.push_back({1'b1, 32'h00000013});
      end else if (sv >= -2048 && sv <= 2047) begin
         exp_q.push_back({1'b1, m_addi(lo_u, 0, rd)});
      end else if (lo_u == 0) begin
         exp_q.push_back({1'b1, m_lui(v / 4096, rd)});
      end else begin
         up = v - 32'(lo_s);
         exp_q.push_back({1'b0, m_lui(up / 4096, rd)});
         exp_q.push_back({1'b1, m_addi(lo_u, rd, rd)});
      end
   endfunction

   // One clock: score outputs at the falling edge, then advance past the rising edge.
   task automatic cycle();
      logic [32:0] e;
      logic        exp_rdy;
      @(negedge clk);
      exp_rdy = !reset && ((exp_q.size() == 0) || (exp_q.size() == 1 && out_ready));
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      if (out_valid && out_ready && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("sb_instr", out_instr, e[31:0]);
         chk("sb_last", {31'd0, out_last}, {31'd0, e[32]});
      end
      if (in_valid && in_ready) model_push(in_value, in_rd);
      @(posedge clk);
      if (reset) exp_q.delete();
      #1;
   endtask

   task automatic directed(input string tag, input logic [31:0] v, input logic [4:0] rd,
                           input logic [31:0] w0, input logic [31:0] w1, input bit two);
      in_valid  = 1'b1;
      in_value  = v;
      in_rd     = rd;
      out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      in_value = $urandom;
      chk({tag, "_w0"}, out_instr, w0);
      chk({tag, "_l0"}, {31'd0, out_last}, {31'd0, !two});
      cycle();
      if (two) begin
         chk({tag, "_w1"}, out_instr, w1);
         chk({tag, "_l1"}, {31'd0, out_last}, 32'd1);
         cycle();
      end
      chk({tag, "_idle"}, {31'd0, out_valid}, 32'd0);
   endtask

   function automatic logic [31:0] rand_value();
      logic [31:0] v;
      case ($urandom_range(0, 5))
         0:       v = 32'($urandom_range(0, 4095)) - 32'd2048;
         1:       v = $urandom & 32'hFFFFF000;
         2:       v = 32'h7FFFF800;
         3:       v = 32'hFFFFF7FF;
         default: v = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_rd     = 5'd0;
      in_value  = 32'd0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      cycle();
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_instr", out_instr, 32'd0);
      chk("rst_last", {31'd0, out_last}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      reset = 1'b0;
      #1;
      chk("in_ready_idle", {31'd0, in_ready}, 32'd1);

      directed("pair", 32'h12345678, 5'd5, 32'h123452B7, 32'h67828293, 1'b1);
      directed("carry", 32'hDEADBEEF, 5'd10, 32'hDEADC537, 32'hEEF50513, 1'b1);
      directed("neg1", 32'hFFFFFFFF, 5'd1, 32'hFFF00093, 32'd0, 1'b0);
      directed("lui", 32'h00001000, 5'd2, 32'h00001137, 32'd0, 1'b0);
      directed("rd0", 32'hDEADBEEF, 5'd0, 32'h00000013, 32'd0, 1'b0);

      in_valid  = 1'b1;
      in_value  = 32'd5;
      in_rd     = 5'd1;
      out_ready = 1'b1;
      cycle();
      chk("b2b_w0", out_instr, 32'h00500093);
      chk("b2b_rdy0", {31'd0, in_ready}, 32'd1);
      in_value = 32'h00002000;
      in_rd    = 5'd4;
      cycle();
      chk("b2b_w1", out_instr, 32'h00002237);
      chk("b2b_rdy1", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      cycle();
      chk("b2b_idle", {31'd0, out_valid}, 32'd0);

      in_valid  = 1'b1;
      in_value  = 32'h7FFFF800;
      in_rd     = 5'd3;
      out_ready = 1'b0;
      cycle();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("stall_w0", out_instr, 32'h800001B7);
         chk("stall_v", {31'd0, out_valid}, 32'd1);
         chk("stall_l", {31'd0, out_last}, 32'd0);
         cycle();
      end
      out_ready = 1'b1;
      cycle();
      chk("stall_w1", out_instr, 32'h80018193);
      chk("stall_l1", {31'd0, out_last}, 32'd1);
      cycle();
      chk("stall_idle", {31'd0, out_valid}, 32'd0);

      in_valid  = 1'b1;
      out_ready = 1'b0;
      cycle();
      in_valid = 1'b0;
      cycle();
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      chk("rst_mid_second", out_instr, 32'h80018193);
      reset = 1'b1;
      cycle();
      chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
      reset     = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("rst_mid_rdy", {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("rst_no_addi", {31'd0, out_valid}, 32'd0);
      end

      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         in_value  = rand_value();
         in_rd     = 5'($urandom_range(0, 31));
         cycle();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) cycle();
      chk("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
